// File: rtl/uart_rx_fifo_if.sv
// Bus bundle between the UART receiver/FIFO and its host: serial line in, pop/clear strobes in,
// FIFO head, occupancy, error flags and interrupt out.
interface uart_rx_fifo_if #(
   parameter int fifoDepth = 8
);
   logic                       serialDataInput;
   logic                       readPop;
   logic                       errorClear;
   logic [7:0]                 readData;
   logic                       dataAvailable;
   logic [$clog2(fifoDepth):0] fifoCount;
   logic                       overrunError;
   logic                       framingError;
   logic                       rxInterrupt;

   modport master (
      output serialDataInput, readPop, errorClear,
      input  readData, dataAvailable, fifoCount, overrunError, framingError, rxInterrupt
   );

   modport slave (
      input  serialDataInput, readPop, errorClear,
      output readData, dataAvailable, fifoCount, overrunError, framingError, rxInterrupt
   );
endinterface

// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver feeding a show-ahead FIFO with sticky overrun/framing flags.
// Define UART_RX_IRQ_EN to build the registered rxInterrupt; otherwise it is tied low.
module uart_rx_fifo #(
   parameter int clocksPerBit = 108,
   parameter int fifoDepth    = 8
) (
   input logic           clock,
   input logic           resetActiveLow,
   uart_rx_fifo_if.slave bus
);
   localparam int TW = $clog2(clocksPerBit);
   localparam int PW = $clog2(fifoDepth);
   localparam int CW = PW + 1;
   localparam logic [TW-1:0] TIMER_HALF = TW'(clocksPerBit / 2);
   localparam logic [TW-1:0] TIMER_LAST = TW'(clocksPerBit - 1);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   logic sync_a, sync_b, valid_a, valid_b, armed;
   state_t state, state_n;
   logic [TW-1:0] timer, timer_n;
   logic [2:0] bit_idx, bit_n;
   logic [7:0] shift, shift_n;
   logic push_req, frame_err;

   logic [7:0] mem [fifoDepth];
   logic [PW-1:0] wr_ptr, rd_ptr;
   logic [CW-1:0] count;
   logic full, empty, pop_ok, push_ok, overrun_set;
   logic overrun, framing;

   // armed means the previous synchronized sample was a genuine high, so a line held low
   // through reset release never looks like a falling edge.
   always_ff @(posedge clock or negedge resetActiveLow) begin
      if (!resetActiveLow) begin
         sync_a  <= 1'b1;
         sync_b  <= 1'b1;
         valid_a <= 1'b0;
         valid_b <= 1'b0;
         armed   <= 1'b0;
      end else begin
         sync_a  <= bus.serialDataInput;
         sync_b  <= sync_a;
         valid_a <= 1'b1;
         valid_b <= valid_a;
         armed   <= valid_b & sync_b;
      end
   end

   always_ff @(posedge clock or negedge resetActiveLow) begin
      if (!resetActiveLow) begin
         state   <= IDLE;
         timer   <= '0;
         bit_idx <= '0;
         shift   <= '0;
      end else begin
         state   <= state_n;
         timer   <= timer_n;
         bit_idx <= bit_n;
         shift   <= shift_n;
      end
   end

   always_comb begin
      state_n   = state;
      timer_n   = timer;
      bit_n     = bit_idx;
      shift_n   = shift;
      push_req  = 1'b0;
      frame_err = 1'b0;
      case (state)
         IDLE: begin
            timer_n = '0;
            bit_n   = '0;
            if (armed && !sync_b) state_n = START;
         end
         START: begin
            if (timer == TIMER_HALF) begin
               timer_n = '0;
               state_n = sync_b ? IDLE : DATA;
            end else begin
               timer_n = timer + TW'(1);
            end
         end
         DATA: begin
            if (timer == TIMER_LAST) begin
               timer_n = '0;
               shift_n = {sync_b, shift[7:1]};
               bit_n   = bit_idx + 3'd1;
               if (bit_idx == 3'd7) state_n = STOP;
            end else begin
               timer_n = timer + TW'(1);
            end
         end
         STOP: begin
            if (timer == TIMER_LAST) begin
               timer_n   = '0;
               push_req  = sync_b;
               frame_err = !sync_b;
               state_n   = IDLE;
            end else begin
               timer_n = timer + TW'(1);
            end
         end
         default: state_n = IDLE;
      endcase
   end

   // A pop in the same cycle frees the slot, so a push onto a full FIFO is then accepted.
   assign full        = (count == CW'(fifoDepth));
   assign empty       = (count == '0);
   assign pop_ok      = bus.readPop && !empty;
   assign push_ok     = push_req && (!full || pop_ok);
   assign overrun_set = push_req && full && !pop_ok;

   always_ff @(posedge clock) begin
      if (push_ok) mem[wr_ptr] <= shift;
   end

   always_ff @(posedge clock or negedge resetActiveLow) begin
      if (!resetActiveLow) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + PW'(1);
         if (pop_ok) rd_ptr <= rd_ptr + PW'(1);
         case ({push_ok, pop_ok})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   // Setting beats clearing when both land in the same cycle.
   always_ff @(posedge clock or negedge resetActiveLow) begin
      if (!resetActiveLow) begin
         overrun <= 1'b0;
         framing <= 1'b0;
      end else begin
         if (overrun_set) overrun <= 1'b1;
         else if (bus.errorClear) overrun <= 1'b0;
         if (frame_err) framing <= 1'b1;
         else if (bus.errorClear) framing <= 1'b0;
      end
   end

   assign bus.readData      = empty ? 8'h00 : mem[rd_ptr];
   assign bus.dataAvailable = !empty;
   assign bus.fifoCount     = count;
   assign bus.overrunError  = overrun;
   assign bus.framingError  = framing;

`ifdef UART_RX_IRQ_EN
   logic irq;

   always_ff @(posedge clock or negedge resetActiveLow) begin
      if (!resetActiveLow) irq <= 1'b0;
      else irq <= !empty | overrun | framing;
   end

   assign bus.rxInterrupt = irq;
`else
   assign bus.rxInterrupt = 1'b0;
`endif
endmodule

// File: doc/uart_rx_fifo.md
UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 SHALL have parameter clocksPerBit, default 108: cpuClock cycles per serial bit, integer >= 4.
REQ-002 SHALL have parameter fifoDepth, default 8: receive FIFO entries, power of two, 2..64.
REQ-003 SHALL have port clock  input  1  rising-edge clock (driven by cpuClock in the SoC).
REQ-004 SHALL have port resetActiveLow  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port serialDataInput  input  1  asynchronous 8N1 line, idle high.
REQ-006 SHALL have port readPop  input  1  one-cycle pulse that removes the FIFO head.
REQ-007 SHALL have port errorClear  input  1  one-cycle pulse that clears the sticky error flags.
REQ-008 SHALL have port readData  output  8  FIFO head byte, show-ahead.
REQ-009 SHALL have port dataAvailable  output  1  FIFO not empty.
REQ-010 SHALL have port fifoCount  output  $clog2(fifoDepth)+1  current FIFO occupancy.
REQ-011 SHALL have port overrunError  output  1  sticky flag: a byte was dropped because the FIFO was full.
REQ-012 SHALL have port framingError  output  1  sticky flag: a stop bit was sampled low.
REQ-013 SHALL have port rxInterrupt  output  1  level interrupt, defined under Configuration.

Function
REQ-014 SHALL pass serialDataInput through a 2-flop synchronizer, initialised high, before any use; total input latency 2 cycles.
REQ-015 SHALL implement FSM states IDLE, START, DATA, STOP, with a bit-timer counter and a 3-bit bit index.
REQ-016 IDLE -> START on a synchronized high-to-low transition; the bit timer loads 0.
REQ-017 START: at timer == clocksPerBit/2 (integer division), line high -> IDLE (glitch rejected, nothing pushed); line low -> DATA with timer reset to 0.
REQ-018 DATA: sample once at each timer == clocksPerBit-1; shift LSB first; after the 8th sample -> STOP.
REQ-019 STOP: sample at timer == clocksPerBit-1; high -> push byte; low -> set framingError, discard byte; both cases -> IDLE in the next cycle.
REQ-020 A push SHALL occur in the same cycle as the stop sample; readData/dataAvailable SHALL reflect the byte on the following cycle when the FIFO was empty.
REQ-021 A push while full SHALL drop the byte, leave the FIFO contents unchanged, and set overrunError.
REQ-022 Simultaneous readPop and push while full: the pop SHALL apply first, the push SHALL be accepted, fifoCount SHALL be unchanged, and overrunError SHALL NOT be set.
REQ-023 Simultaneous readPop and push while not full and not empty: fifoCount unchanged, order preserved.
REQ-024 readPop while empty SHALL be ignored; readData is then don't-care but SHALL be stable.
REQ-025 Read/write pointers SHALL wrap modulo fifoDepth; fifoCount SHALL range 0..fifoDepth.
REQ-026 errorClear SHALL clear both error flags in the next cycle; a same-cycle set SHALL win over clear.

Reset
REQ-027 While resetActiveLow is low: FSM = IDLE, timer = 0, bit index = 0, pointers = 0, fifoCount = 0, dataAvailable = 0, overrunError = 0, framingError = 0, rxInterrupt = 0, synchronizer = 1, readData = 0.
REQ-028 A reset asserted mid-frame SHALL abort the frame with no push; after release, the FSM SHALL wait for a new falling edge (a line still low SHALL NOT start a frame).
REQ-029 FIFO storage contents need no reset; only the pointers and count are reset.

Configuration
REQ-030 Macro UART_RX_IRQ_EN defined: rxInterrupt = dataAvailable | overrunError | framingError, registered (one cycle after the cause).
REQ-031 Macro UART_RX_IRQ_EN undefined: rxInterrupt is tied to constant 0 and no interrupt logic is synthesised; all other behaviour is identical.

Verification
REQ-032 Idle line; send 0xA5 at clocksPerBit=108 -> one push; dataAvailable=1, readData=0xA5, fifoCount=1, no error flags set.
REQ-033 Send 8 bytes 0x00..0x07 with no pops, then a 9th byte 0xFF -> fifoCount=8, overrunError=1; popping 8 times returns 0x00..0x07 in order, then dataAvailable=0.
REQ-034 With the FIFO full, pulse readPop in the exact stop-sample cycle of byte 0x3C -> fifoCount stays 8, overrunError=0, and the last entry read out is 0x3C.
REQ-035 Hold the line low for 20 cycles, then high -> returns to IDLE at the mid-start sample, no push, no flags set.
REQ-036 Frame 0x55 with the stop bit driven low -> framingError=1, fifoCount=0; pulse errorClear -> framingError=0 in the next cycle.
REQ-037 Assert reset during DATA bit 4 while the line is held low across release -> no push, FSM in IDLE; the next valid frame 0x81 is received correctly; with UART_RX_IRQ_EN defined, rxInterrupt rises one cycle after dataAvailable.
